div_nonrestoring_seq: RTL and testbench

//  Sequential signed 32-bit integer divider for the multdiv unit. It is the counterpart of the multiplier datapath:
//  the multiplier shifts its product register right each step; this block shifts the {remainder,quotient} register left.
//  One non-restoring iteration per cycle. Started by a ctrl_DIV pulse; the result is reported by a one-cycle ready pulse.

---
 rtl/div_nonrestoring_seq.sv | 184 ++++++++++++++++++
 tb/tb_div_nonrestoring_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_nonrestoring_seq.sv
// -----------------------------------------------------------------------------
// div_nonrestoring_seq
//
// Sequential signed integer divider for the multdiv unit. The divider works on
// operand magnitudes and applies the signs at the end. Each cycle it performs
// one non-restoring step on a {remainder, quotient} register that shifts left.
//
// Operation
//   start edge   : latch the operand signs and magnitudes, clear the partial
//                  remainder. A divisor of zero goes to DZ, otherwise to RUN.
//   RUN x WIDTH  : one quotient bit per cycle.
//   FIX          : restore a negative remainder, apply the signs, and pulse
//                  data_resultRDY.
//   DZ           : report divide-by-zero with the dividend as the remainder.
// A start pulse in any state aborts the operation in flight. The aborted
// operation does not produce a ready pulse.
//
// Ports
//   clock           in   1      rising-edge clock
//   reset_n         in   1      asynchronous active-low reset
//   ctrl_DIV        in   1      start pulse; operands sampled on that edge
//   data_operandA   in   WIDTH  dividend, two's complement
//   data_operandB   in   WIDTH  divisor, two's complement
//   data_result     out  WIDTH  quotient, truncated toward zero
//   data_remainder  out  WIDTH  remainder, with the sign of the dividend
//   data_exception  out  1      divide-by-zero flag
//   data_resultRDY  out  1      one-cycle completion pulse; outputs valid then
// -----------------------------------------------------------------------------
module div_nonrestoring_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DZ   = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             sa;      // dividend sign
  logic             sb;      // divisor sign
  logic [WIDTH-1:0] q;       // |dividend|, which becomes the quotient one bit per step
  logic [WIDTH-1:0] d;       // |divisor|
  logic [WIDTH:0]   p;       // signed partial remainder, one guard bit wide

  // Magnitudes of the operands as unsigned values. |-2^(WIDTH-1)| wraps to
  // 2^(WIDTH-1), which is still the correct unsigned magnitude.
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  // One non-restoring step, plus the final correction and the sign fix-up.
  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   p_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH:0]   p_fix;
  logic [WIDTH-1:0] q_signed;
  logic [WIDTH-1:0] r_signed;
  logic [WIDTH-1:0] dz_rem;
  logic             last_iter;

  // NOTE: every signal assigned in always_comb gets a default value first. A
  // path that leaves a signal unassigned would infer a latch.
  always_comb begin
    abs_a     = data_operandA;
    abs_b     = data_operandB;
    p_shift   = '0;
    p_step    = '0;
    q_step    = '0;
    p_fix     = p;
    q_signed  = q;
    r_signed  = '0;
    dz_rem    = q;
    last_iter = 1'b0;

    if (data_operandA[WIDTH-1]) abs_a = -data_operandA;
    if (data_operandB[WIDTH-1]) abs_b = -data_operandB;

    // Shift {P,Q} left by one. The top quotient bit enters the remainder.
    p_shift = {p[WIDTH-1:0], q[WIDTH-1]};

    // If the previous remainder is non-negative, subtract the divisor;
    // otherwise add it back. The resulting sign gives the quotient bit.
    if (p[WIDTH]) p_step = p_shift + {1'b0, d};
    else          p_step = p_shift - {1'b0, d};
    q_step = {q[WIDTH-2:0], ~p_step[WIDTH]};

    // A negative final remainder is restored once. The quotient bits already
    // match those of restoring division, so they need no correction.
    if (p[WIDTH]) p_fix = p + {1'b0, d};

    // The quotient takes the XOR of the signs. The remainder follows the
    // dividend. Negating 2^(WIDTH-1) wraps, which gives -2^(WIDTH-1) / -1 its
    // wrapped result.
    if (sa ^ sb) q_signed = -q;
    r_signed = sa ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0];

    // In DZ, q still holds |A|. Re-applying the sign gives back the latched A.
    if (sa) dz_rem = -q;

    last_iter = (count == CW'(WIDTH - 1));
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together on the edge, and the order of statements does not
  // matter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      count          <= '0;
      sa             <= 1'b0;
      sb             <= 1'b0;
      q              <= '0;
      d              <= '0;
      p              <= '0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      // The ready pulse lasts one cycle unless a completion below sets it again.
      data_resultRDY <= 1'b0;

      if (ctrl_DIV) begin
        // A start has priority in every state. It aborts any operation in flight.
        sa    <= data_operandA[WIDTH-1];
        sb    <= data_operandB[WIDTH-1];
        q     <= abs_a;
        d     <= abs_b;
        p     <= '0;
        count <= '0;
        state <= (data_operandB == '0) ? DZ : RUN;
      end else begin
        unique case (state)
          IDLE: ;

          RUN: begin
            p <= p_step;
            q <= q_step;
            if (last_iter) begin
              count <= '0;
              state <= FIX;
            end else begin
              count <= count + 1'b1;
            end
          end

          FIX: begin
            p              <= p_fix;
            data_result    <= q_signed;
            data_remainder <= r_signed;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b1;
            state          <= IDLE;
          end

          DZ: begin
            data_result    <= '0;
            data_remainder <= dz_rem;
            data_exception <= 1'b1;
            data_resultRDY <= 1'b1;
            state          <= IDLE;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_nonrestoring_seq.sv
// -----------------------------------------------------------------------------
// tb_div_nonrestoring_seq
//
// Testbench for div_nonrestoring_seq.
//
// A behavioural model predicts the DUT outputs from plain signed arithmetic and
// the completion latency. The model keeps one pending result and a countdown to
// its ready cycle. A new start replaces the pending result, and reset clears
// everything.
//
// A compare process checks all outputs against the model on every falling
// edge. Directed cases also check hand-computed literal results and latencies.
// -----------------------------------------------------------------------------
module tb_div_nonrestoring_seq;

  localparam int W = 32;

  logic         clock;
  logic         reset_n;
  logic         ctrl_DIV;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic [W-1:0] data_result;
  logic [W-1:0] data_remainder;
  logic         data_exception;
  logic         data_resultRDY;

  int vectors     = 0;
  int miscompares = 0;

  div_nonrestoring_seq #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: 64-bit signed division truncates toward zero, so the
  // remainder takes the sign of the dividend. Computing in 64 bits avoids the
  // 32-bit overflow case. The low word then holds the wrapped quotient.
  function automatic logic [31:0] ref_quot(input logic [31:0] a, input logic [31:0] b);
    longint al, bl, ql;
    al = longint'($signed(a));
    bl = longint'($signed(b));
    ql = al / bl;
    return ql[31:0];
  endfunction

  function automatic logic [31:0] ref_rem(input logic [31:0] a, input logic [31:0] b);
    longint al, bl, rl;
    al = longint'($signed(a));
    bl = longint'($signed(b));
    rl = al % bl;
    return rl[31:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic        m_busy;
  int          m_left;
  logic [31:0] p_res, p_rem;
  logic        p_exc;
  logic [31:0] m_res, m_rem;
  logic        m_exc, m_rdy;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_left <= 0;
      p_res  <= '0;
      p_rem  <= '0;
      p_exc  <= 1'b0;
      m_res  <= '0;
      m_rem  <= '0;
      m_exc  <= 1'b0;
      m_rdy  <= 1'b0;
    end else begin
      m_rdy <= 1'b0;
      if (ctrl_DIV) begin
        m_busy <= 1'b1;
        if (data_operandB == 32'd0) begin
          m_left <= 1;
          p_res  <= 32'd0;
          p_rem  <= data_operandA;
          p_exc  <= 1'b1;
        end else begin
          m_left <= 33;
          p_res  <= ref_quot(data_operandA, data_operandB);
          p_rem  <= ref_rem(data_operandA, data_operandB);
          p_exc  <= 1'b0;
        end
      end else if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_rdy  <= 1'b1;
          m_res  <= p_res;
          m_rem  <= p_rem;
          m_exc  <= p_exc;
        end
      end
    end
  end

  // Compare process: outputs must match the model on every cycle.
  logic prev_rdy = 1'b0;
  always @(negedge clock) begin
    check("rdy", data_resultRDY, m_rdy);
    check("result", data_result, m_res);
    check("remainder", data_remainder, m_rem);
    check("exception", data_exception, m_exc);
    if (prev_rdy) check("rdy_width", data_resultRDY, 1'b0);
    prev_rdy <= data_resultRDY;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Returns just after the start edge E0.
  task automatic pulse(input logic [31:0] a, input logic [31:0] b);
    @(posedge clock);
    #1;
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Latency is counted in cycles from the start edge to the cycle where RDY is
  // high. The wait is bounded, so a missing pulse shows up as a huge latency.
  task automatic wait_rdy(output int lat);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!data_resultRDY && n < 60);
    lat = data_resultRDY ? n - 1 : 999;
  endtask

  task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [31:0] erem,
                        input logic ee, input int elat);
    int lat;
    pulse(a, b);
    wait_rdy(lat);
    check({name, "_lat"}, lat, elat);
    check({name, "_res"}, data_result, er);
    check({name, "_rem"}, data_remainder, erem);
    check({name, "_exc"}, data_exception, ee);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int          lat;
    logic [31:0] a, b;
    int          gap;

    reset_n       = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    check("reset_res", data_result, 32'd0);
    check("reset_rdy", data_resultRDY, 1'b0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Directed cases with hand-computed expectations.
    do_div("t1", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    do_div("t2a", -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);
    do_div("t2b", 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 33);
    do_div("t3dz", 32'd5, 32'd0, 32'd0, 32'd5, 1'b1, 1);
    do_div("t3clr", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    do_div("t4a", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
    do_div("t4b", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 33);

    // An abort by a second start at cycle 10 gives a single RDY, counted from the second start.
    pulse(32'd100, 32'd7);
    repeat (8) @(posedge clock);
    pulse(32'd9, 32'd2);
    wait_rdy(lat);
    check("t5_lat", lat, 33);
    check("t5_res", data_result, 32'd4);
    check("t5_rem", data_remainder, 32'd1);

    // A reset in the middle of an operation clears the outputs at once and produces no RDY.
    pulse(32'd100, 32'd7);
    repeat (19) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("t6_res", data_result, 32'd0);
    check("t6_rem", data_remainder, 32'd0);
    check("t6_rdy", data_resultRDY, 1'b0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (40) begin
      @(negedge clock);
      check("t6_no_rdy", data_resultRDY, 1'b0);
    end
    do_div("t6b", 32'd63, 32'd8, 32'd7, 32'd7, 1'b0, 33);

    // Randomized operands, with corner values mixed in and occasional aborts.
    for (int i = 0; i < 1200; i++) begin
      case ($urandom % 16)
        0:       begin a = $urandom; b = 32'd0; end
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       begin a = 32'h8000_0000; b = $urandom; end
        3:       begin a = $urandom; b = 32'h8000_0000; end
        4, 5:    begin a = $urandom; b = $urandom_range(1, 16); end
        6:       begin a = $urandom; b = -$urandom_range(1, 16); end
        7:       begin a = $urandom_range(0, 100); b = $urandom; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      if (b == 32'd0 && a == 32'd0) a = 32'd1;
      pulse(a, b);
      if ($urandom % 8 == 0) begin
        gap = $urandom_range(0, 32);
        repeat (gap) @(posedge clock);
      end else begin
        wait_rdy(lat);
        check("rand_lat", lat, (b == 32'd0) ? 1 : 33);
        repeat ($urandom_range(0, 2)) @(posedge clock);
      end
    end

    repeat (40) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
